// File: rtl/dp_ram_be.sv
// True dual-port synchronous RAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write behaviour, write-collision flag and post-reset zero fill.
module dp_ram_be #(
    parameter int unsigned DATA     = 32,
    parameter int unsigned ADDR     = 6,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned WR_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                busy,
    output logic                coll,
    input  logic                a_en,
    input  logic                a_wr,
    input  logic [DATA/8-1:0]   a_be,
    input  logic [ADDR-1:0]     a_addr,
    input  logic [DATA-1:0]     a_din,
    output logic [DATA-1:0]     a_dout,
    output logic                a_valid,
    input  logic                b_en,
    input  logic                b_wr,
    input  logic [DATA/8-1:0]   b_be,
    input  logic [ADDR-1:0]     b_addr,
    input  logic [DATA-1:0]     b_din,
    output logic [DATA-1:0]     b_dout,
    output logic                b_valid
);

    localparam int unsigned DEPTH = 2**ADDR;
    localparam int unsigned NBYTE = DATA / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ADDR-1:0] ptr;
    logic [ADDR-1:0] ptr_next;

    logic [DATA-1:0] mem [DEPTH];

    logic            a_acc_c;
    logic            b_acc_c;
    logic            a_we_c;
    logic            b_we_c;
    logic            both_c;
    logic [DATA-1:0] a_old_c;
    logic [DATA-1:0] b_old_c;
    logic [DATA-1:0] a_mrg_c;
    logic [DATA-1:0] b_mrg_c;
    logic [DATA-1:0] ab_mrg_c;
    logic [DATA-1:0] a_wdata_c;
    logic [DATA-1:0] b_wdata_c;
    logic [DATA-1:0] a_rdata_c;
    logic [DATA-1:0] b_rdata_c;

    logic            a_v1;
    logic            b_v1;
    logic [DATA-1:0] a_d1;
    logic [DATA-1:0] b_d1;

    // Clear/run sequencer: state and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            busy  <= (state_next == CLEAR);
        end
    end

    // Pointer walks the whole array once, then parks on the last address
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            CLEAR: begin
                if (ptr == ADDR'(DEPTH - 1)) begin
                    state_next = RUN;
                end else begin
                    ptr_next = ptr + ADDR'(1);
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    // Request qualification and byte-merge of write data against the stored word
    always_comb begin
        a_acc_c = a_en && (state == RUN) && !rst;
        b_acc_c = b_en && (state == RUN) && !rst;
        a_we_c  = a_acc_c && a_wr;
        b_we_c  = b_acc_c && b_wr;
        both_c  = a_we_c && b_we_c && (a_addr == b_addr);
        a_old_c = mem[a_addr];
        b_old_c = mem[b_addr];
        a_mrg_c  = a_old_c;
        b_mrg_c  = b_old_c;
        ab_mrg_c = a_old_c;
        for (int i = 0; i < NBYTE; i++) begin
            if (a_be[i]) a_mrg_c[8*i +: 8] = a_din[8*i +: 8];
            if (b_be[i]) b_mrg_c[8*i +: 8] = b_din[8*i +: 8];
            // Same-address double write: A owns bytes both ports enable
            if (a_be[i]) begin
                ab_mrg_c[8*i +: 8] = a_din[8*i +: 8];
            end else if (b_be[i]) begin
                ab_mrg_c[8*i +: 8] = b_din[8*i +: 8];
            end
        end
        a_wdata_c = both_c ? ab_mrg_c : a_mrg_c;
        b_wdata_c = both_c ? ab_mrg_c : b_mrg_c;
        a_rdata_c = (a_we_c && (WR_FIRST != 0)) ? a_wdata_c : a_old_c;
        b_rdata_c = (b_we_c && (WR_FIRST != 0)) ? b_wdata_c : b_old_c;
    end

    // Storage array; zero fill during the clear sequence
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else begin
            if (a_we_c) mem[a_addr] <= a_wdata_c;
            if (b_we_c) mem[b_addr] <= b_wdata_c;
        end
    end

    // First output stage and collision flag; dout only moves with a valid
    always_ff @(posedge clk) begin
        if (rst) begin
            a_v1 <= 1'b0;
            b_v1 <= 1'b0;
            a_d1 <= '0;
            b_d1 <= '0;
            coll <= 1'b0;
        end else begin
            a_v1 <= a_acc_c;
            b_v1 <= b_acc_c;
            if (a_acc_c) a_d1 <= a_rdata_c;
            if (b_acc_c) b_d1 <= b_rdata_c;
            coll <= both_c;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic            a_v2;
            logic            b_v2;
            logic [DATA-1:0] a_d2;
            logic [DATA-1:0] b_d2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_v2 <= 1'b0;
                    b_v2 <= 1'b0;
                    a_d2 <= '0;
                    b_d2 <= '0;
                end else begin
                    a_v2 <= a_v1;
                    b_v2 <= b_v1;
                    if (a_v1) a_d2 <= a_d1;
                    if (b_v1) b_d2 <= b_d1;
                end
            end

            assign a_valid = a_v2;
            assign b_valid = b_v2;
            assign a_dout  = a_d2;
            assign b_dout  = b_d2;
        end else begin : g_lat1
            assign a_valid = a_v1;
            assign b_valid = b_v1;
            assign a_dout  = a_d1;
            assign b_dout  = b_d1;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_be.sv
// Scoreboard bench for dp_ram_be: two instances (RD_LAT=1/WR_FIRST=1 and
// RD_LAT=2/WR_FIRST=0) share stimulus and are checked against one memory model.
module tb_dp_ram_be;

    localparam int unsigned DEPTH = 16;

    typedef struct {
        int          id;
        logic [31:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, a_wr = 1'b0, b_en = 1'b0, b_wr = 1'b0;
    logic [3:0]  a_be = '0, b_be = '0, a_addr = '0, b_addr = '0;
    logic [31:0] a_din = '0, b_din = '0;

    logic        busy1, coll1, a_valid1, b_valid1;
    logic        busy2, coll2, a_valid2, b_valid2;
    logic [31:0] a_dout1, b_dout1, a_dout2, b_dout2;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          cnt     = DEPTH;
    logic [31:0] m [DEPTH];
    logic [31:0] last_d [4];
    exp_t        sb [$];

    always #5 clk = ~clk;

    dp_ram_be #(.DATA(32), .ADDR(4), .RD_LAT(1), .WR_FIRST(1)) u_dut1 (
        .clk(clk), .rst(rst), .busy(busy1), .coll(coll1),
        .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout1), .a_valid(a_valid1),
        .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout1), .b_valid(b_valid1)
    );

    dp_ram_be #(.DATA(32), .ADDR(4), .RD_LAT(2), .WR_FIRST(0)) u_dut2 (
        .clk(clk), .rst(rst), .busy(busy2), .coll(coll2),
        .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout2), .a_valid(a_valid2),
        .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout2), .b_valid(b_valid2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_port(input int p, input logic v, input logic [31:0] d);
        int k[$];
        k = sb.find_first_index(x) with (x.id == p);
        if (v === 1'b1) begin
            if (k.size() == 0) begin
                check($sformatf("p%0d_unexpected_valid", p), 32'd1, 32'd0);
            end else begin
                check($sformatf("p%0d_valid_cycle", p), 32'(cyc), 32'(sb[k[0]].c));
                check($sformatf("p%0d_dout", p), d, sb[k[0]].d);
                sb.delete(k[0]);
            end
            last_d[p] = d;
        end else begin
            check($sformatf("p%0d_dout_hold", p), d, last_d[p]);
            check($sformatf("p%0d_valid_x", p), 32'(v), 32'd0);
            if (k.size() != 0 && sb[k[0]].c <= cyc) begin
                check($sformatf("p%0d_missing_valid", p), 32'd0, 32'd1);
                sb.delete(k[0]);
            end
        end
    endtask

    // One clock: predict the edge from the model, clock, then compare at negedge
    task automatic step();
        logic [31:0] oa, ob, ma, mb, mm, fa, fb;
        logic        acc_a, acc_b, wa, wb, both;
        acc_a = a_en && !rst && (cnt == 0);
        acc_b = b_en && !rst && (cnt == 0);
        wa    = acc_a && a_wr;
        wb    = acc_b && b_wr;
        both  = wa && wb && (a_addr == b_addr);
        oa = m[a_addr];
        ob = m[b_addr];
        ma = oa; mb = ob; mm = oa;
        for (int i = 0; i < 4; i++) begin
            if (a_be[i]) ma[8*i +: 8] = a_din[8*i +: 8];
            if (b_be[i]) mb[8*i +: 8] = b_din[8*i +: 8];
            if (a_be[i])      mm[8*i +: 8] = a_din[8*i +: 8];
            else if (b_be[i]) mm[8*i +: 8] = b_din[8*i +: 8];
        end
        fa = both ? mm : ma;
        fb = both ? mm : mb;
        if (rst) begin
            sb.delete();
            cnt = DEPTH;
            for (int i = 0; i < DEPTH; i++) m[i] = '0;
            for (int i = 0; i < 4; i++) last_d[i] = '0;
        end else begin
            if (acc_a) begin
                sb.push_back('{0, wa ? fa : oa, cyc + 1});
                sb.push_back('{2, oa, cyc + 2});
            end
            if (acc_b) begin
                sb.push_back('{1, wb ? fb : ob, cyc + 1});
                sb.push_back('{3, ob, cyc + 2});
            end
            if (wa) m[a_addr] = fa;
            if (wb) m[b_addr] = fb;
            if (cnt > 0) cnt--;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("busy1", 32'(busy1), 32'(cnt != 0));
        check("busy2", 32'(busy2), 32'(cnt != 0));
        check("coll1", 32'(coll1), 32'(both));
        check("coll2", 32'(coll2), 32'(both));
        check_port(0, a_valid1, a_dout1);
        check_port(1, b_valid1, b_dout1);
        check_port(2, a_valid2, a_dout2);
        check_port(3, b_valid2, b_dout2);
    endtask

    task automatic set_a(input logic en, input logic wr, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] din);
        a_en = en; a_wr = wr; a_be = be; a_addr = addr; a_din = din;
    endtask

    task automatic set_b(input logic en, input logic wr, input logic [3:0] be,
                         input logic [3:0] addr, input logic [31:0] din);
        b_en = en; b_wr = wr; b_be = be; b_addr = addr; b_din = din;
    endtask

    task automatic idle(input int n);
        set_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        set_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (busy1 === 1'b1 && n < 40) begin
            step();
            n++;
        end
        check(tag, 32'(n), 32'd16);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        for (int i = 0; i < 4; i++) last_d[i] = '0;

        // Reset and clear sequence
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("rst_a_dout1", a_dout1, 32'h0);
        check("rst_b_dout2", b_dout2, 32'h0);
        rst = 1'b0;
        wait_clear("busy_len");

        // Every address reads back zero
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
            set_b(1'b1, 1'b0, 4'h0, 4'(15 - i), 32'h0);
            step();
        end
        idle(3);

        // Byte enables on port A
        set_a(1'b1, 1'b1, 4'b1111, 4'd5, 32'hAABBCCDD); step();
        set_a(1'b1, 1'b1, 4'b0101, 4'd5, 32'h11223344); step();
        set_a(1'b1, 1'b0, 4'b0000, 4'd5, 32'h0);        step();
        idle(3);

        // Same-address double write
        set_a(1'b1, 1'b1, 4'b0011, 4'd9, 32'h000000FF);
        set_b(1'b1, 1'b1, 4'b0110, 4'd9, 32'h12345678);
        step();
        set_a(1'b1, 1'b0, 4'b0000, 4'd9, 32'h0);
        set_b(1'b1, 1'b0, 4'b0000, 4'd9, 32'h0);
        step();
        idle(3);

        // Write on A races a read on B
        set_a(1'b1, 1'b1, 4'b1111, 4'd3, 32'h55); step();
        set_a(1'b1, 1'b1, 4'b1111, 4'd3, 32'h77);
        set_b(1'b1, 1'b0, 4'b0000, 4'd3, 32'h0);  step();
        set_a(1'b0, 1'b0, 4'b0000, 4'd0, 32'h0);  step();
        idle(3);

        // Fill with random data, then back-to-back reads on both ports
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1'b1, 1'b1, 4'b1111, 4'(i), $urandom);
            step();
        end
        idle(1);
        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
            set_b(1'b1, 1'b0, 4'h0, 4'(i + 8), 32'h0);
            step();
        end
        idle(3);

        // Mixed random traffic on a narrow address range to provoke collisions
        for (int i = 0; i < 200; i++) begin
            set_a(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), $urandom);
            set_b(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)), $urandom);
            step();
        end
        idle(3);

        // Reset while reads are in flight
        set_a(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        set_b(1'b1, 1'b0, 4'h0, 4'd8, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(0);
        wait_clear("busy_len_rerun");
        set_a(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
        set_b(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
        step();
        idle(4);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
